// File: rtl/mem_io_responder.sv
// Byte FIFO used on both the tx and rx sides of the IO responder.
// Latency: head visible the cycle after push; count updates at every edge.
// Backpressure: a push is taken when not full or when a pop shares the cycle.
module mem_io_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop,
    output logic                       o_push_ok,
    output logic [W-1:0]               o_head_dat,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop   = i_pop && (r_count != '0);
    assign w_do_push  = i_push && ((r_count < (AW+1)'(DEPTH)) || w_do_pop);
    assign o_push_ok  = w_do_push;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage array: written on accepted push, contents never cleared.
    always_ff @(posedge clk_in) begin
        if (w_do_push && !rst_in) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; simultaneous push/pop keeps count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// CPU-side memory/IO responder: byte RAM, UART tx/rx FIFOs, cycle counter.
// Latency: writes take effect at the edge; read data registered, 1 cycle.
// Backpressure: none on the bus; tx bytes dropped when full, rx_ready = !full.
module mem_io_responder #(
    parameter int RAM_ADDR_WID = 17,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        prog_done,
    output logic        tx_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]  r_ram [0:(1<<RAM_ADDR_WID)-1];
    logic [7:0]  r_mem_din;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_snapshot;
    logic        r_prog_done;
    logic        r_tx_overflow;

    logic                    w_io;
    logic [15:0]             w_off;
    logic [RAM_ADDR_WID-1:0] w_ram_addr;
    logic                    w_rd_rx;
    logic                    w_rd_cnt;
    logic                    w_wr_stop;
    logic                    w_tx_push;
    logic [7:0]              w_tx_push_dat;
    logic                    w_tx_push_ok;
    logic                    w_tx_pop;
    logic [CW-1:0]           w_tx_count;
    logic                    w_rx_push;
    logic                    w_rx_pop;
    logic                    w_rx_push_ok;
    logic [7:0]              w_rx_head;
    logic [CW-1:0]           w_rx_count;
    logic [7:0]              w_rd_dat;
    logic                    w_unused_addr;

    assign w_unused_addr = ^mem_a[31:18] ^ w_rx_push_ok;

    assign w_io       = (mem_a[17:16] == 2'b11);
    assign w_off      = mem_a[15:0];
    assign w_ram_addr = mem_a[RAM_ADDR_WID-1:0];

    assign w_rd_rx   = !mem_wr && w_io && (w_off == 16'h0000);
    assign w_rd_cnt  = !mem_wr && w_io && (w_off == 16'h0004);
    assign w_wr_stop = mem_wr && w_io && !r_prog_done && (w_off == 16'h0004);

    // Zero bytes on the data port are filtered; the stop port always sends 0x00.
    assign w_tx_push = w_wr_stop ||
                       (mem_wr && w_io && !r_prog_done && (w_off == 16'h0000) && (mem_dout != 8'h00));
    assign w_tx_push_dat = w_wr_stop ? 8'h00 : mem_dout;
    assign w_tx_pop      = tx_valid && tx_ready;

    assign w_rx_push = rx_valid && rx_ready;
    assign w_rx_pop  = w_rd_rx && (w_rx_count != '0);

    mem_io_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_push     (w_tx_push),
        .i_push_dat (w_tx_push_dat),
        .i_pop      (w_tx_pop),
        .o_push_ok  (w_tx_push_ok),
        .o_head_dat (tx_data),
        .o_count    (w_tx_count)
    );

    mem_io_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_push     (w_rx_push),
        .i_push_dat (rx_data),
        .i_pop      (w_rx_pop),
        .o_push_ok  (w_rx_push_ok),
        .o_head_dat (w_rx_head),
        .o_count    (w_rx_count)
    );

    assign tx_valid       = (w_tx_count != '0);
    assign rx_ready       = (w_rx_count < CW'(FIFO_DEPTH));
    assign io_buffer_full = (w_tx_count >= CW'(FIFO_DEPTH - 2));
    assign mem_din        = r_mem_din;
    assign prog_done      = r_prog_done;
    assign tx_overflow    = r_tx_overflow;

    // Read data select; an empty rx FIFO returns zero rather than bypassing.
    always_comb begin
        w_rd_dat = 8'h00;
        if (!w_io) begin
            w_rd_dat = r_ram[w_ram_addr];
        end else begin
            case (w_off)
                16'h0000: w_rd_dat = (w_rx_count != '0) ? w_rx_head : 8'h00;
                16'h0004: w_rd_dat = r_cycle_cnt[7:0];
                16'h0005: w_rd_dat = r_snapshot[15:8];
                16'h0006: w_rd_dat = r_snapshot[23:16];
                16'h0007: w_rd_dat = r_snapshot[31:24];
                default:  w_rd_dat = 8'h00;
            endcase
        end
    end

    // RAM write port; contents survive reset, but writes during reset are dropped.
    always_ff @(posedge clk_in) begin
        if (!rst_in && mem_wr && !w_io) begin
            r_ram[w_ram_addr] <= mem_dout;
        end
    end

    // Read data register, cycle counter, snapshot and sticky flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mem_din     <= 8'h00;
            r_cycle_cnt   <= 32'h0;
            r_snapshot    <= 32'h0;
            r_prog_done   <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'h1;
            if (!mem_wr)                   r_mem_din     <= w_rd_dat;
            if (w_rd_cnt)                  r_snapshot    <= r_cycle_cnt;
            if (w_wr_stop)                 r_prog_done   <= 1'b1;
            if (w_tx_push && !w_tx_push_ok) r_tx_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with scoreboard queues for read data and tx bytes.
// Latency: every bus cycle's mem_din is checked one edge later against the queue head.
// Backpressure: tx_ready toggled by the sequence; rx_valid driven per step.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = 32'h0003_0008;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h00;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        prog_done;
    logic        tx_overflow;

    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    logic [7:0] model_din = 8'h00;
    logic [7:0] din_q [$];
    logic [8:0] tx_q [$];

    mem_io_responder #(.RAM_ADDR_WID(17), .FIFO_DEPTH(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .prog_done      (prog_done),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: reads push the expected byte, writes push the held value.
    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d, input logic [7:0] exp);
        logic [7:0] e;
        mem_wr = wr; mem_a = a; mem_dout = d;
        if (rst_in)   model_din = 8'h00;
        else if (!wr) model_din = exp;
        din_q.push_back(model_din);
        @(posedge clk_in);
        #1;
        model_cnt = rst_in ? 0 : model_cnt + 1;
        e = din_q.pop_front();
        chk("mem_din", {24'h0, mem_din}, {24'h0, e});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 32'h0003_0008, 8'h00, 8'h00);
    endtask

    // tx stream monitor: every handshake must match the next expected byte.
    always @(negedge clk_in) begin
        logic [8:0] e;
        if (tx_valid && tx_ready) begin
            e = (tx_q.size() > 0) ? tx_q.pop_front() : 9'h100;
            chk("tx_byte", {23'h0, 1'b0, tx_data}, {23'h0, e});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with IO and RAM writes attempted while held.
        rst_in = 1'b1;
        bus(1'b1, 32'h0003_0000, 8'h51, 8'h00);
        bus(1'b1, 32'h0003_0004, 8'h00, 8'h00);
        idle(1);
        rst_in = 1'b0;
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        chk("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        chk("rst_prog_done", {31'h0, prog_done}, 32'h0);
        chk("rst_overflow", {31'h0, tx_overflow}, 32'h0);

        // RAM write then read-after-write, and hold during write cycles.
        bus(1'b1, 32'h0000_0010, 8'hA5, 8'h00);
        bus(1'b0, 32'h0000_0010, 8'h00, 8'hA5);
        bus(1'b1, 32'h0001_FFFF, 8'h3C, 8'h00);
        bus(1'b0, 32'h0001_FFFF, 8'h00, 8'h3C);
        bus(1'b0, 32'h0000_0010, 8'h00, 8'hA5);
        bus(1'b0, 32'h0003_0100, 8'h00, 8'h00);

        // Counter read at a known value.
        bus(1'b0, 32'h0003_0004, 8'h00, 8'(model_cnt));

        // tx stream with zero filtering.
        tx_ready = 1'b1;
        bus(1'b1, 32'h0003_0000, 8'h48, 8'h00); tx_q.push_back(9'h048);
        bus(1'b1, 32'h0003_0000, 8'h00, 8'h00);
        bus(1'b1, 32'h0003_0000, 8'h69, 8'h00); tx_q.push_back(9'h069);
        idle(5);
        chk("tx_drain_hi", tx_q.size(), 0);

        // Fill tx FIFO with no drain: near-full after 6, overflow on the 9th.
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus(1'b1, 32'h0003_0000, 8'(i), 8'h00);
            if (i <= 8) tx_q.push_back(9'(i));
            if (i == 5) chk("buf_full_5", {31'h0, io_buffer_full}, 32'h0);
            if (i == 6) chk("buf_full_6", {31'h0, io_buffer_full}, 32'h1);
            if (i == 8) chk("overflow_8", {31'h0, tx_overflow}, 32'h0);
        end
        chk("overflow_9", {31'h0, tx_overflow}, 32'h1);
        tx_ready = 1'b1;
        idle(10);
        chk("tx_drain_fill", tx_q.size(), 0);
        chk("buf_full_empty", {31'h0, io_buffer_full}, 32'h0);

        // rx pushes then reads, third read on empty FIFO.
        rx_valid = 1'b1; rx_data = 8'h31; idle(1);
        rx_data = 8'h32; idle(1);
        rx_valid = 1'b0;
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h31);
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h32);
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h00);

        // Empty rx with simultaneous push and read: no bypass, byte kept.
        rx_valid = 1'b1; rx_data = 8'h55;
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h00);
        rx_valid = 1'b0;
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h55);

        // Fill rx FIFO, offer one more byte, drain in order.
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'hA0 + 8'(i);
            idle(1);
        end
        chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        rx_data = 8'hEE; idle(1);
        rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) bus(1'b0, 32'h0003_0000, 8'h00, 8'hA0 + 8'(i));
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h00);
        chk("rx_ready_empty", {31'h0, rx_ready}, 32'h1);

        // Snapshot consistency at cycle_cnt = 0x1FF.
        for (int g = 0; g < 1000 && model_cnt < 32'h1FF; g++) idle(1);
        chk("cnt_at_1ff", model_cnt, 32'h1FF);
        bus(1'b0, 32'h0003_0004, 8'h00, 8'hFF);
        bus(1'b0, 32'h0003_0005, 8'h00, 8'h01);
        bus(1'b0, 32'h0003_0006, 8'h00, 8'h00);
        bus(1'b0, 32'h0003_0007, 8'h00, 8'h00);

        // Program stop: 0x00 emitted, later IO writes ignored, RAM still live.
        bus(1'b1, 32'h0003_0004, 8'h77, 8'h00); tx_q.push_back(9'h000);
        chk("prog_done_set", {31'h0, prog_done}, 32'h1);
        bus(1'b1, 32'h0003_0000, 8'h58, 8'h00);
        bus(1'b1, 32'h0003_0004, 8'h00, 8'h00);
        idle(4);
        chk("tx_drain_stop", tx_q.size(), 0);
        chk("tx_valid_stop", {31'h0, tx_valid}, 32'h0);
        bus(1'b1, 32'h0000_0100, 8'h5A, 8'h00);
        bus(1'b0, 32'h0000_0100, 8'h00, 8'h5A);

        // Mid-operation reset discards rx contents and sticky flags.
        rx_valid = 1'b1; rx_data = 8'h77; idle(1);
        rx_valid = 1'b0;
        rst_in = 1'b1;
        idle(2);
        rst_in = 1'b0;
        chk("rst2_prog_done", {31'h0, prog_done}, 32'h0);
        chk("rst2_overflow", {31'h0, tx_overflow}, 32'h0);
        chk("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h00);
        bus(1'b0, 32'h0003_0004, 8'h00, 8'h01);
        bus(1'b0, 32'h0003_0005, 8'h00, 8'h00);
        bus(1'b0, 32'h0000_0010, 8'h00, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_ADDR_WID, default 17: RAM byte-address width (128 KB).
REQ-002 Parameter FIFO_DEPTH, default 8: entries in each of the tx and rx byte FIFOs (power of two, >=4).
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 mem_a  input  32  bus address from CPU; only [17:0] decoded.
REQ-006 mem_wr  input  1  1 = write cycle, 0 = read cycle.
REQ-007 mem_dout  input  8  CPU write data.
REQ-008 mem_din  output  8  registered read data to CPU.
REQ-009 io_buffer_full  output  1  tx FIFO near-full indication to CPU.
REQ-010 tx_valid / tx_data / tx_ready  output 1 / output 8 / input 1  outgoing byte stream (UART tx side).
REQ-011 rx_valid / rx_data / rx_ready  input 1 / input 8 / output 1  incoming byte stream (UART rx side).
REQ-012 prog_done  output  1  sticky program-stop flag.
REQ-013 tx_overflow  output  1  sticky flag, tx byte dropped because FIFO full.

Function
REQ-014 Decode: io = (mem_a[17:16]==2'b11); otherwise RAM at mem_a[RAM_ADDR_WID-1:0].
REQ-015 Every cycle is a bus transaction (no enable); CPU holds an address for exactly the cycles it intends.
REQ-016 RAM write: mem_wr=1, !io -> ram[addr] <= mem_dout at that edge; write completes in 1 cycle, no wait.
REQ-017 Read latency exactly 1: read in cycle N -> mem_din valid in cycle N+1; during a write cycle mem_din holds its previous value.
REQ-018 RAM read after write to same address in the next cycle returns the new byte.
REQ-019 IO read 0x30000: if rx FIFO non-empty, return head and pop one entry per cycle addressed; if empty, return 0x00, no pop.
REQ-020 IO read 0x30004: return cycle_cnt[7:0] and latch snapshot <= cycle_cnt; reads of 0x30005/6/7 return snapshot bytes 1/2/3.
REQ-021 cycle_cnt: 32-bit, 0 in first cycle after reset, +1 every cycle, wraps 0xFFFFFFFF->0.
REQ-022 IO write 0x30000: non-zero byte pushed to tx FIFO; 0x00 ignored.
REQ-023 IO write 0x30004: push 0x00 to tx FIFO (bypasses zero filter) and set prog_done; after prog_done, all IO writes ignored, RAM unaffected.
REQ-024 Other IO addresses: reads return 0x00, writes ignored.
REQ-025 tx push accepted if count<FIFO_DEPTH or a tx pop occurs in the same cycle; otherwise byte dropped, tx_overflow set.
REQ-026 tx_valid = tx FIFO non-empty; tx_data = head; pop on tx_valid & tx_ready.
REQ-027 io_buffer_full = (tx count >= FIFO_DEPTH-2), combinational from count, giving two in-flight write slots.
REQ-028 rx_ready = rx FIFO not full; push on rx_valid & rx_ready; push and pop in same cycle leave count unchanged.
REQ-029 rx FIFO empty with simultaneous push and 0x30000 read: read returns 0x00, no bypass, pushed byte stored.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-031 While rst_in=1 at an edge: mem_din=0x00, cycle_cnt=0, snapshot=0, both FIFOs empty, prog_done=0, tx_overflow=0; bus writes (RAM and IO) ignored.
REQ-032 Outputs after reset: tx_valid=0, rx_ready=1, io_buffer_full=0; RAM contents not reset.
REQ-033 Reset mid-operation discards all FIFO contents and pending snapshot in the same edge.

Verification
REQ-034 Write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after read.
REQ-035 Writes 'H',0x00,'i' to 0x30000, tx_ready=1 -> tx stream emits 0x48,0x69 only.
REQ-036 FIFO_DEPTH=8, tx_ready=0, 6 writes -> io_buffer_full=1; 3 more -> 8 stored, tx_overflow=1.
REQ-037 rx pushes 0x31,0x32; two reads of 0x30000, then a third -> mem_din 0x31, 0x32, 0x00.
REQ-038 Read 0x30004..0x30007 in consecutive cycles at cycle_cnt=0x000001FF -> bytes 0xFF,0x01,0x00,0x00 (snapshot consistent).
REQ-039 Write 0x30004 -> prog_done=1, tx emits 0x00; later write 'X' to 0x30000 -> no tx byte.
